// File: rtl/ex_mem_skid_register_if.sv
// EX/MEM handshake bundle: execute-side inputs, memory-side outputs and the
// valid/ready pair on each side. The slave modport is the register's own view;
// the master modport is the surrounding pipeline's view.
interface ex_mem_skid_register_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // execute side
  logic                      flush;
  logic                      inValid;
  logic                      inReady;
  logic [2:0]                memControlInput;
  logic [1:0]                wbControlInput;
  logic [DATA_WIDTH-1:0]     aluResultInput;
  logic                      aluZeroInput;
  logic [DATA_WIDTH-1:0]     pcInput;
  logic [DATA_WIDTH-1:0]     registerDataInput;
  logic [REG_ADDR_WIDTH-1:0] writeRegisterInput;

  // memory side
  logic                      outValid;
  logic                      outReady;
  logic                      branch;
  logic                      memRead;
  logic                      memWrite;
  logic [1:0]                wbControlExMem;
  logic [DATA_WIDTH-1:0]     aluResult;
  logic                      aluZero;
  logic [DATA_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     registerData;
  logic [REG_ADDR_WIDTH-1:0] writeRegister;
  logic                      branchTaken;
  logic [1:0]                occupancy;

  modport slave (
    input  flush, inValid, memControlInput, wbControlInput, aluResultInput,
           aluZeroInput, pcInput, registerDataInput, writeRegisterInput,
           outReady,
    output inReady, outValid, branch, memRead, memWrite, wbControlExMem,
           aluResult, aluZero, pc, registerData, writeRegister, branchTaken,
           occupancy
  );

  modport master (
    output flush, inValid, memControlInput, wbControlInput, aluResultInput,
           aluZeroInput, pcInput, registerDataInput, writeRegisterInput,
           outReady,
    input  inReady, outValid, branch, memRead, memWrite, wbControlExMem,
           aluResult, aluZero, pc, registerData, writeRegister, branchTaken,
           occupancy
  );
endinterface

// File: rtl/ex_mem_skid_register.sv
// EX/MEM pipeline register with valid/ready flow control, optional one-entry
// skid buffer and synchronous flush. With SKID_ENABLE=1 inReady comes straight
// from a flop, so a memory-stage stall never forms a combinational path back
// into execute; the skid entry absorbs the one entry already in flight.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_EMPTY | no entry held, outValid=0, occupancy 0
// S_ONE   | head holds one entry, occupancy 1
// S_FULL  | head and skid both hold entries, inReady=0 (skid mode only)
module ex_mem_skid_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit SKID_ENABLE    = 1'b1
) (
  input logic                   clock,
  input logic                   resetN,
  ex_mem_skid_register_if.slave bus
);

  typedef struct packed {
    logic [2:0]                mem_ctl;    // {branch, memRead, memWrite}
    logic [1:0]                wb_ctl;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      alu_zero;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     reg_data;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  entry_t r_head;
  entry_t w_skid;
  entry_t w_in_entry;
  logic   r_in_ready;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_accept;
  logic   w_drain;
  logic   w_load_head_in;
  logic   w_load_head_skid;
  logic   w_load_skid;

  assign w_in_entry = '{
    mem_ctl:    bus.memControlInput,
    wb_ctl:     bus.wbControlInput,
    alu_result: bus.aluResultInput,
    alu_zero:   bus.aluZeroInput,
    pc:         bus.pcInput,
    reg_data:   bus.registerDataInput,
    write_reg:  bus.writeRegisterInput
  };

  assign w_out_valid = (r_state != S_EMPTY);

  // r_in_ready is 0 in reset and 1 from the first edge after release. In skid
  // mode it is the whole story; in single-register mode it only gates the
  // combinational "head free or leaving" term so reset still forces inReady=0.
  generate
    if (SKID_ENABLE) begin : g_ready_reg
      assign w_in_ready = r_in_ready;
    end else begin : g_ready_comb
      assign w_in_ready = r_in_ready & (!w_out_valid | bus.outReady);
    end
  endgenerate

  assign w_accept = bus.inValid & w_in_ready;
  assign w_drain  = w_out_valid & bus.outReady;

  // State register and registered inReady (high unless heading into FULL).
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_FULL);
    end
  end

  // Next-state and load selection; flush overrides every handshake.
  always_comb begin
    w_state_next     = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_next   = S_ONE;
            w_load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            w_load_head_in = 1'b1;
          end else if (w_accept) begin
            // Without a skid register inReady already implies drain here.
            if (SKID_ENABLE) begin
              w_state_next = S_FULL;
              w_load_skid  = 1'b1;
            end
          end else if (w_drain) begin
            w_state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_drain) begin
            w_state_next     = S_ONE;
            w_load_head_skid = 1'b1;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
        end
      endcase
    end
  end

  // Head register: payload presented to the memory stage.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_head <= '0;
    end else if (w_load_head_in) begin
      r_head <= w_in_entry;
    end else if (w_load_head_skid) begin
      r_head <= w_skid;
    end
  end

  generate
    if (SKID_ENABLE) begin : g_skid
      entry_t r_skid;

      // Skid register: catches the entry accepted in the cycle the stall was seen.
      always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
          r_skid <= '0;
        end else if (w_load_skid) begin
          r_skid <= w_in_entry;
        end
      end

      assign w_skid = r_skid;
    end else begin : g_no_skid
      assign w_skid = '0;
    end
  endgenerate

  // Control fields are forced to bubbles when nothing is valid; data fields
  // keep their last value and are meaningless while outValid=0.
  assign bus.inReady        = w_in_ready;
  assign bus.outValid       = w_out_valid;
  assign bus.branch         = w_out_valid & r_head.mem_ctl[2];
  assign bus.memRead        = w_out_valid & r_head.mem_ctl[1];
  assign bus.memWrite       = w_out_valid & r_head.mem_ctl[0];
  assign bus.wbControlExMem = w_out_valid ? r_head.wb_ctl : 2'b00;
  assign bus.branchTaken    = w_out_valid & r_head.mem_ctl[2] & r_head.alu_zero;
  assign bus.aluResult      = r_head.alu_result;
  assign bus.aluZero        = r_head.alu_zero;
  assign bus.pc             = r_head.pc;
  assign bus.registerData   = r_head.reg_data;
  assign bus.writeRegister  = r_head.write_reg;
  assign bus.occupancy      = r_state;

endmodule

// File: doc/ex_mem_skid_register.md
# ex_mem_skid_register

Parametrised EX/MEM pipeline register with valid/ready flow control, a one-entry skid buffer, and synchronous flush. It sits between the execute stage and the memory stage of the pipelined datapath. It lets the memory stage stall without a combinational ready path back into execute, and lets branch/exception logic squash in-flight instructions into bubbles. Occupancy is 0–2 entries.

## Interface
- DATA_WIDTH, 32, width of ALU result, PC/branch target and store data.
- REG_ADDR_WIDTH, 5, width of destination register index.
- SKID_ENABLE, 1, 1 = two-entry skid mode with registered inReady; 0 = single register with combinational inReady.

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all held and incoming entries.
- inValid  in  1  execute stage presents an entry.
- inReady  out  1  block can accept this cycle.
- memControlInput  in  3  {branch, memRead, memWrite}, bit 2 down to 0.
- wbControlInput  in  2  write-back control.
- aluResultInput  in  DATA_WIDTH  ALU result / address.
- aluZeroInput  in  1  ALU zero flag.
- pcInput  in  DATA_WIDTH  branch target.
- registerDataInput  in  DATA_WIDTH  store data.
- writeRegisterInput  in  REG_ADDR_WIDTH  destination register.
- outValid  out  1  head entry valid.
- outReady  in  1  memory stage consumes the head entry.
- branch, memRead, memWrite  out  1 each  head control bits.
- wbControlExMem  out  2  head write-back control.
- aluResult, pc, registerData  out  DATA_WIDTH  head payload.
- aluZero  out  1  head zero flag.
- writeRegister  out  REG_ADDR_WIDTH  head destination.
- branchTaken  out  1  outValid & branch & aluZero.
- occupancy  out  2  number of valid entries (0..2).

## Operation
- accept = inValid & inReady; drain = outValid & outReady.
- Storage: head register drives the outputs. A skid register exists only when SKID_ENABLE=1.
- States (SKID_ENABLE=1):
  - EMPTY, occupancy 0.
    - accept → ONE (head ← input).
  - ONE, occupancy 1.
    - accept & drain → ONE (head ← input).
    - accept & !drain → FULL (skid ← input).
    - !accept & drain → EMPTY.
    - otherwise hold.
  - FULL, occupancy 2; inReady=0.
    - drain → ONE (head ← skid).
    - otherwise hold.
- inReady = (state != FULL), driven from a register. It has no combinational dependency on outReady.
- SKID_ENABLE=0:
  - inReady = !outValid | outReady (combinational).
  - accept loads head.
  - drain without accept → EMPTY.
  - Occupancy never exceeds 1.
- Ordering: entries leave in acceptance order. No entry is lost or duplicated.
- Bubble rule: branch, memRead, memWrite, wbControlExMem and branchTaken are 0 whenever outValid=0.
- Data fields (aluResult, aluZero, pc, registerData, writeRegister) hold their last value when the block empties. The memory stage must not use them while outValid=0.
- flush has the highest priority:
  - Next state EMPTY.
  - Any same-cycle accept is discarded.
  - Control outputs are 0 from the next cycle.
  - inReady is 1 the cycle after the flush.
- Reset (resetN=0): all outputs and internal registers go to 0 immediately and asynchronously.
  - inReady=0 while resetN=0, and 1 from the first clock edge after release.
  - Reset mid-transfer drops all entries.

## Timing
- Latency: an entry accepted at edge N is visible on the outputs after edge N; outValid=1 in cycle N+1.
- Throughput: 1 entry/cycle when outReady is held 1, in both modes.
- Stall: the head and its outputs are stable while outValid=1 & outReady=0.
- The skid register absorbs exactly one entry, because inReady deasserts one cycle after the stall is seen.
- Release from FULL: the head shows the skid entry the cycle after drain, and inReady rises the same cycle.
- Simultaneous flush & drain: the drained entry counts as consumed, and the block is EMPTY next cycle.
- Simultaneous accept & drain in ONE: occupancy stays 1 and the head is replaced.

## Test plan
- Reset:
  - Stimulus: hold resetN=0 mid-stream with occupancy=2.
  - Required response: all outputs 0 asynchronously before the next edge.
  - After release, inReady=1 and occupancy=0.
- Streaming:
  - Stimulus: 8 back-to-back entries (aluResultInput = 0x10..0x17), outReady=1.
  - Required response: outputs 0x10..0x17 on consecutive cycles.
  - First entry appears 1 cycle after accept; no gaps.
- Skid:
  - Stimulus: stream entries 0xA0, 0xA1, 0xA2; drop outReady when 0xA0 is at the head.
  - Required response: 0xA1 is captured in skid and inReady=0 with occupancy=2.
  - 0xA2 is held upstream.
  - On outReady=1, outputs are 0xA0, 0xA1, 0xA2 in order.
- Flush:
  - Stimulus: occupancy=2, then assert flush together with inValid=1.
  - Required response: next cycle outValid=0, occupancy=0, memRead=memWrite=branch=0 and wbControlExMem=0.
  - The flushed-cycle input never appears.
- Branch:
  - Stimulus: memControlInput=3'b100, aluZeroInput=1.
  - Required response: branchTaken=1 for exactly the cycles the entry is at the head.
  - With aluZeroInput=0, branchTaken=0.
- SKID_ENABLE=0:
  - Stimulus: repeat the stall scenario.
  - Required response: inReady follows !outValid | outReady combinationally and occupancy never exceeds 1.
  - Order is preserved.
